// File: rtl/intc_vec.sv
// intc_vec: vectored interrupt controller.
// Source events are latched into pending bits and gated by a writable mask.
// The lowest-index enabled pending source is raised to the CPU as irq plus a
// vector address. The request is held until iack, and is followed by one idle
// cycle so that the CPU sees irq deassert.
module intc_vec #(
  parameter int              NSRC       = 4,
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   VEC_BASE   = 32'h0000_0100,
  parameter int              VEC_STRIDE = 4,
  parameter bit              EDGE       = 1'b1,
  parameter logic [NSRC-1:0] MASK_RST   = {NSRC{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src,
  input  logic                     mask_we,
  input  logic [NSRC-1:0]          mask_wdata,
  output logic [NSRC-1:0]          mask,
  output logic [NSRC-1:0]          pending,
  input  logic                     iack,
  output logic                     irq,
  output logic [$clog2(NSRC)-1:0]  irq_id,
  output logic [AW-1:0]            EAddr
);

  localparam int IW = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] clr;
  logic            any_active;
  logic            ack;
  logic [IW-1:0]   sel_id;
  logic [AW-1:0]   sel_addr;
  logic            irq_next;
  logic [IW-1:0]   irq_id_next;
  logic [AW-1:0]   eaddr_next;

  assign active     = pending & mask;
  assign any_active = |active;
  // iack only counts while a request is actually outstanding
  assign ack        = (state == REQ) && iack;

  // One-hot clear of the source being serviced
  always_comb begin
    clr = '0;
    if (ack) clr[irq_id] = 1'b1;
  end

  // Per-source pending update; a new edge wins over a same-cycle clear
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    if (EDGE) begin : g_edge
      assign pending_next[gi] = (src[gi] & ~src_q[gi]) | (pending[gi] & ~clr[gi]);
    end else begin : g_level
      assign pending_next[gi] = src[gi];
    end
  end

  // Source history, pending bits and mask register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      src_q   <= src;
      pending <= pending_next;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Priority encoder: bit 0 is the highest priority
  always_comb begin
    sel_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) sel_id = IW'(i);
    end
  end

  assign sel_addr = VEC_BASE + AW'(sel_id) * AW'(VEC_STRIDE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_active) state_next = REQ;
      REQ:     if (iack)       state_next = GAP;
      GAP:                     state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers at the next edge
  always_comb begin
    irq_next    = irq;
    irq_id_next = irq_id;
    eaddr_next  = EAddr;
    case (state)
      IDLE: begin
        if (any_active) begin
          irq_next    = 1'b1;
          irq_id_next = sel_id;
          eaddr_next  = sel_addr;
        end else begin
          irq_next    = 1'b0;
        end
      end
      REQ:     if (iack) irq_next = 1'b0;
      GAP:     irq_next = 1'b0;
      default: irq_next = 1'b0;
    endcase
  end

  // Registered request outputs; id and vector stay frozen outside IDLE capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq    <= 1'b0;
      irq_id <= '0;
      EAddr  <= VEC_BASE;
    end else begin
      irq    <= irq_next;
      irq_id <= irq_id_next;
      EAddr  <= eaddr_next;
    end
  end

endmodule
